// File: rtl/tt_ctrl_pkg.sv
// Shared types and default constants for the tile mux control sequencer.
package tt_ctrl_pkg;

   localparam int DEF_Y_W         = 5;
   localparam int DEF_X_W         = 5;
   localparam int DEF_G_Y         = 24;
   localparam int DEF_G_X         = 16;
   localparam int DEF_INC_HALF    = 1;
   localparam int DEF_SEL_RST_CYC = 2;
   localparam int DEF_UM_RST_CYC  = 8;
   localparam int TMR_W           = 8;

   typedef logic [DEF_Y_W+DEF_X_W-1:0] addr_t;

   typedef enum logic [2:0] {
      IDLE,
      SEL_RST,
      INC_HI,
      INC_LO,
      UM_RST,
      RUN
   } state_t;

endpackage

// File: rtl/tt_ctrl_timer.sv
// Loadable down-counter; zero is high while the count is 0, so a load of N-1 gives an N-cycle wait.
module tt_ctrl_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - W'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/tt_ctrl_seq.sv
// Tile mux sequencer: reset select counter, pulse it to {y,x}, enable and reset the user module; requests only in IDLE/RUN.
// Define TT_CTRL_SEQ_SHORTCUT_EN to step forward from RUN without a select-counter reset.
module tt_ctrl_seq
   import tt_ctrl_pkg::*;
#(
   parameter int Y_W         = DEF_Y_W,
   parameter int X_W         = DEF_X_W,
   parameter int G_Y         = DEF_G_Y,
   parameter int G_X         = DEF_G_X,
   parameter int INC_HALF    = DEF_INC_HALF,
   parameter int SEL_RST_CYC = DEF_SEL_RST_CYC,
   parameter int UM_RST_CYC  = DEF_UM_RST_CYC
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [Y_W-1:0]     req_y,
   input  logic [X_W-1:0]     req_x,
   output logic               ctrl_sel_rst_n,
   output logic               ctrl_sel_inc,
   output logic               ctrl_ena,
   output logic               um_rst_n,
   output logic [Y_W+X_W-1:0] cur_addr,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int A_W = Y_W + X_W;
   localparam logic [Y_W:0] G_Y_L = (Y_W+1)'(G_Y);
   localparam logic [X_W:0] G_X_L = (X_W+1)'(G_X);

   state_t             state, state_nxt;
   logic [A_W-1:0]     target;
   logic [A_W-1:0]     req_addr;
   logic               accept, bad_req, out_of_range;
   logic               tmr_load, tmr_zero;
   logic [TMR_W-1:0]   tmr_val;

   assign req_addr     = {req_y, req_x};
   assign out_of_range = ({1'b0, req_y} >= G_Y_L) || ({1'b0, req_x} >= G_X_L);

   tt_ctrl_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      accept    = 1'b0;
      bad_req   = 1'b0;
      case (state)
         IDLE, RUN: begin
            if (req_valid) begin
               if (out_of_range) begin
                  bad_req = 1'b1;
               end else begin
                  accept = 1'b1;
`ifdef TT_CTRL_SEQ_SHORTCUT_EN
                  if (state == RUN && req_addr >= cur_addr) begin
                     tmr_load = 1'b1;
                     if (req_addr == cur_addr) begin
                        state_nxt = UM_RST;
                        tmr_val   = TMR_W'(UM_RST_CYC - 1);
                     end else begin
                        state_nxt = INC_HI;
                        tmr_val   = TMR_W'(INC_HALF - 1);
                     end
                  end else begin
                     state_nxt = SEL_RST;
                     tmr_load  = 1'b1;
                     tmr_val   = TMR_W'(SEL_RST_CYC - 1);
                  end
`else
                  state_nxt = SEL_RST;
                  tmr_load  = 1'b1;
                  tmr_val   = TMR_W'(SEL_RST_CYC - 1);
`endif
               end
            end
         end
         SEL_RST: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               if (target != '0) begin
                  state_nxt = INC_HI;
                  tmr_val   = TMR_W'(INC_HALF - 1);
               end else begin
                  state_nxt = UM_RST;
                  tmr_val   = TMR_W'(UM_RST_CYC - 1);
               end
            end
         end
         INC_HI: begin
            if (tmr_zero) begin
               state_nxt = INC_LO;
               tmr_load  = 1'b1;
               tmr_val   = TMR_W'(INC_HALF - 1);
            end
         end
         INC_LO: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               if (cur_addr == target) begin
                  state_nxt = UM_RST;
                  tmr_val   = TMR_W'(UM_RST_CYC - 1);
               end else begin
                  state_nxt = INC_HI;
                  tmr_val   = TMR_W'(INC_HALF - 1);
               end
            end
         end
         UM_RST: begin
            if (tmr_zero)
               state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // cur_addr mirrors the external select counter: cleared with it, bumped on each falling inc edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         target   <= '0;
         cur_addr <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= (state_nxt == RUN) && (state != RUN);
         err   <= bad_req;
         if (accept)
            target <= req_addr;
         if (state_nxt == SEL_RST)
            cur_addr <= '0;
         else if (state == INC_HI && state_nxt == INC_LO)
            cur_addr <= cur_addr + A_W'(1);
      end
   end

   assign req_ready      = (state == IDLE) || (state == RUN);
   assign busy           = !req_ready;
   assign ctrl_sel_rst_n = (state != IDLE) && (state != SEL_RST);
   assign ctrl_sel_inc   = (state == INC_HI);
   assign ctrl_ena       = (state == UM_RST) || (state == RUN);
   assign um_rst_n       = (state == RUN);

endmodule
